// File: rtl/led_matrix_scanner_if.sv
// Bundle between the game controller and the LED matrix scanner: frame
// patterns and scan controls in, row/column drive and status out.
interface led_matrix_scanner_if;
    logic       enable;
    logic       load;
    logic [6:0] col1_in;
    logic [6:0] col2_in;
    logic [6:0] col3_in;
    logic [6:0] col4_in;
    logic [6:0] col5_in;
    logic       blink_en;
    logic [6:0] row_out;
    logic [4:0] col_sel;
    logic       frame_done;
    logic       busy;

    modport master (
        output enable, load, col1_in, col2_in, col3_in, col4_in, col5_in, blink_en,
        input  row_out, col_sel, frame_done, busy
    );

    modport slave (
        input  enable, load, col1_in, col2_in, col3_in, col4_in, col5_in, blink_en,
        output row_out, col_sel, frame_done, busy
    );
endinterface

// File: rtl/led_matrix_scanner.sv
// 7x5 LED matrix scanner: blanked column-by-column multiplexing of a
// double-buffered frame, with whole-matrix blinking on a frame-count timer.
module led_matrix_scanner #(
    parameter int unsigned COL_CYCLES     = 50000,
    parameter int unsigned BLANK_CYCLES   = 500,
    parameter int unsigned BLINK_FRAMES   = 25,
    parameter bit          COL_ACTIVE_LOW = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    led_matrix_scanner_if.slave    bus
);

    localparam int unsigned TICK_MAX = (COL_CYCLES > BLANK_CYCLES) ? COL_CYCLES : BLANK_CYCLES;
    localparam int unsigned TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam int unsigned FRAME_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [TICK_W-1:0]  BLANK_LAST = TICK_W'(BLANK_CYCLES - 1);
    localparam logic [TICK_W-1:0]  COL_LAST   = TICK_W'(COL_CYCLES - 1);
    localparam logic [TICK_W-1:0]  TICK_ZERO  = TICK_W'(0);
    localparam logic [TICK_W-1:0]  TICK_ONE   = TICK_W'(1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);
    localparam logic [FRAME_W-1:0] FRAME_ZERO = FRAME_W'(0);
    localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(1);
    localparam logic [4:0]         COL_IDLE   = COL_ACTIVE_LOW ? 5'b11111 : 5'b00000;
    localparam logic [2:0]         LAST_COL   = 3'd4;

    typedef logic [4:0][6:0] frame_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    function automatic logic [4:0] col_sel_of(input logic [2:0] idx);
        logic [4:0] onehot;
        case (idx)
            3'd0:    onehot = 5'b00001;
            3'd1:    onehot = 5'b00010;
            3'd2:    onehot = 5'b00100;
            3'd3:    onehot = 5'b01000;
            3'd4:    onehot = 5'b10000;
            default: onehot = 5'b00000;
        endcase
        return onehot ^ COL_IDLE;
    endfunction

    function automatic logic [6:0] row_of(input frame_t frame, input logic [2:0] idx);
        logic [6:0] row;
        case (idx)
            3'd0:    row = frame[0];
            3'd1:    row = frame[1];
            3'd2:    row = frame[2];
            3'd3:    row = frame[3];
            3'd4:    row = frame[4];
            default: row = 7'h00;
        endcase
        return row;
    endfunction

    state_t             state_r;
    logic [2:0]         col_idx_r;
    logic [TICK_W-1:0]  tick_r;
    frame_t             active_r;
    frame_t             shadow_r;
    logic               pending_r;
    logic [FRAME_W-1:0] frame_cnt_r;
    logic               blink_phase_r;
    logic [6:0]         row_out_r;
    logic [4:0]         col_sel_r;
    logic               frame_done_r;
    logic               busy_r;

    frame_t             in_frame_s;
    frame_t             swap_frame_s;
    logic               swap_now_s;
    logic [6:0]         drive_row_s;

    assign in_frame_s   = {bus.col5_in, bus.col4_in, bus.col3_in, bus.col2_in, bus.col1_in};
    // A load arriving on the swap cycle bypasses the shadow so it is not lost.
    assign swap_frame_s = bus.load ? in_frame_s : shadow_r;
    assign swap_now_s   = bus.load | pending_r;
    assign drive_row_s  = (bus.blink_en && blink_phase_r) ? 7'h00 : row_of(active_r, col_idx_r);

    // Scan FSM, frame double buffer, blink timer and registered line drive
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            col_idx_r     <= 3'd0;
            tick_r        <= TICK_ZERO;
            active_r      <= {5{7'h00}};
            shadow_r      <= {5{7'h00}};
            pending_r     <= 1'b0;
            frame_cnt_r   <= FRAME_ZERO;
            blink_phase_r <= 1'b0;
            row_out_r     <= 7'h00;
            col_sel_r     <= COL_IDLE;
            frame_done_r  <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            if (bus.load) begin
                shadow_r  <= in_frame_s;
                pending_r <= 1'b1;
            end else begin
                shadow_r  <= shadow_r;
            end

            if (!bus.enable) begin
                state_r   <= IDLE;
                col_idx_r <= 3'd0;
                tick_r    <= TICK_ZERO;
                row_out_r <= 7'h00;
                col_sel_r <= COL_IDLE;
                busy_r    <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r   <= BLANK;
                        col_idx_r <= 3'd0;
                        tick_r    <= TICK_ZERO;
                        row_out_r <= 7'h00;
                        col_sel_r <= COL_IDLE;
                        busy_r    <= 1'b1;
                        if (swap_now_s) begin
                            active_r  <= swap_frame_s;
                            pending_r <= 1'b0;
                        end else begin
                            active_r  <= active_r;
                        end
                    end
                    BLANK: begin
                        busy_r <= 1'b1;
                        if (tick_r == BLANK_LAST) begin
                            state_r   <= DRIVE;
                            tick_r    <= TICK_ZERO;
                            col_sel_r <= col_sel_of(col_idx_r);
                            row_out_r <= drive_row_s;
                        end else begin
                            tick_r    <= tick_r + TICK_ONE;
                            col_sel_r <= COL_IDLE;
                            row_out_r <= 7'h00;
                        end
                    end
                    DRIVE: begin
                        busy_r <= 1'b1;
                        if (tick_r == COL_LAST) begin
                            state_r   <= BLANK;
                            tick_r    <= TICK_ZERO;
                            col_sel_r <= COL_IDLE;
                            row_out_r <= 7'h00;
                            if (col_idx_r == LAST_COL) begin
                                // Frame boundary: the only point where active and blink state move.
                                col_idx_r    <= 3'd0;
                                frame_done_r <= 1'b1;
                                if (swap_now_s) begin
                                    active_r  <= swap_frame_s;
                                    pending_r <= 1'b0;
                                end else begin
                                    active_r  <= active_r;
                                end
                                if (frame_cnt_r == FRAME_LAST) begin
                                    frame_cnt_r   <= FRAME_ZERO;
                                    blink_phase_r <= ~blink_phase_r;
                                end else begin
                                    frame_cnt_r   <= frame_cnt_r + FRAME_ONE;
                                end
                            end else begin
                                col_idx_r <= col_idx_r + 3'd1;
                            end
                        end else begin
                            tick_r    <= tick_r + TICK_ONE;
                            col_sel_r <= col_sel_of(col_idx_r);
                            row_out_r <= drive_row_s;
                        end
                    end
                    default: begin
                        state_r   <= IDLE;
                        col_idx_r <= 3'd0;
                        tick_r    <= TICK_ZERO;
                        row_out_r <= 7'h00;
                        col_sel_r <= COL_IDLE;
                        busy_r    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.row_out    = row_out_r;
    assign bus.col_sel    = col_sel_r;
    assign bus.frame_done = frame_done_r;
    assign bus.busy       = busy_r;

endmodule
